// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron controller and its ALU.
package lif_pkg;

  // Default datapath width (two's complement).
  localparam int unsigned WIDTH_DEF = 12;

  // ALU function select codes.
  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_CMP = 2'b10;
  localparam logic [1:0] FN_SHR = 2'b11;

  // Controller sequence states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    ADD   = 3'd2,
    CMP   = 3'd3,
    SUB   = 3'd4,
    OUT   = 3'd5
  } state_e;

endpackage

// File: rtl/lif_neuron_ctrl.sv
// Leaky integrate-and-fire sequencer: owns the membrane potential and steps the
// shared ALU through leak, integrate, threshold compare and reset-by-subtraction.
module lif_neuron_ctrl
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int          THRESH = 100,
  parameter int unsigned REFRAC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             spike,
  output logic [WIDTH-1:0] v_out,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_fn,
  input  logic [WIDTH-1:0] alu_x,
  input  logic             alu_cmp
);

  // Counter is at least one bit wide so REFRAC = 0 still elaborates.
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);
  localparam logic [RW-1:0]    REFRAC_W = RW'(REFRAC);
  localparam logic [WIDTH-1:0] V_MAX    = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] V_MIN    = {1'b1, {(WIDTH - 1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] i_lat_q, i_lat_d;
  logic [RW-1:0]    refrac_cnt_q, refrac_cnt_d;
  logic             spike_q, spike_d;

  // Signed overflow of the integrate step (v + i_lat); only consulted in ADD.
  logic ovf_pos, ovf_neg;
  assign ovf_pos = ~v_q[WIDTH-1] & ~i_lat_q[WIDTH-1] &  alu_x[WIDTH-1];
  assign ovf_neg =  v_q[WIDTH-1] &  i_lat_q[WIDTH-1] & ~alu_x[WIDTH-1];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      v_q          <= '0;
      i_lat_q      <= '0;
      refrac_cnt_q <= '0;
      spike_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      i_lat_q      <= i_lat_d;
      refrac_cnt_q <= refrac_cnt_d;
      spike_q      <= spike_d;
    end
  end

  // Next-state logic and ALU operand/function drive, decoded from state.
  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    i_lat_d      = i_lat_q;
    refrac_cnt_d = refrac_cnt_q;
    spike_d      = spike_q;
    alu_fn       = FN_ADD;
    alu_a        = '0;
    alu_b        = '0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          i_lat_d = in_i;
          if (refrac_cnt_q != '0) begin
            // Refractory step: potential frozen, no ALU work.
            refrac_cnt_d = refrac_cnt_q - RW'(1);
            spike_d      = 1'b0;
            state_d      = OUT;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        alu_fn  = FN_SHR;
        alu_a   = v_q;
        v_d     = alu_x;
        state_d = ADD;
      end
      ADD: begin
        alu_fn = FN_ADD;
        alu_a  = v_q;
        alu_b  = i_lat_q;
        if (ovf_pos) begin
          v_d = V_MAX;
        end else if (ovf_neg) begin
          v_d = V_MIN;
        end else begin
          v_d = alu_x;
        end
        state_d = CMP;
      end
      CMP: begin
        // alu_cmp = (B > A) = (v > THRESH), strict.
        alu_fn  = FN_CMP;
        alu_a   = THRESH_W;
        alu_b   = v_q;
        spike_d = alu_cmp;
        state_d = alu_cmp ? SUB : OUT;
      end
      SUB: begin
        // v > THRESH > 0 here, so the subtraction cannot overflow.
        alu_fn       = FN_SUB;
        alu_a        = v_q;
        alu_b        = THRESH_W;
        v_d          = alu_x;
        refrac_cnt_d = REFRAC_W;
        state_d      = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake flags follow the state; result ports mirror the registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    spike     = spike_q;
    v_out     = v_q;
  end

endmodule

// File: tb/tb_lif_neuron_ctrl.sv
// Self-checking bench for lif_neuron_ctrl with a behavioural ALU alongside.
module tb_lif_neuron_ctrl;

  localparam int W       = 12;
  localparam int LAT_MAX = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         spike;
  logic [W-1:0] v_out;
  logic [W-1:0] alu_a, alu_b, alu_x;
  logic [1:0]   alu_fn;
  logic         alu_cmp;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int v;
    bit spk;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit do_rst;
    int cur;
    int exp_v;
    bit exp_spk;
    int exp_lat;
  } vec_t;
  vec_t vecs[13];

  lif_neuron_ctrl #(
    .WIDTH (W),
    .THRESH(100),
    .REFRAC(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_i     (in_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .spike    (spike),
    .v_out    (v_out),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_fn   (alu_fn),
    .alu_x    (alu_x),
    .alu_cmp  (alu_cmp)
  );

  // Reference ALU: add, sub, signed compare (B > A), arithmetic shift right.
  always_comb begin
    alu_x   = '0;
    alu_cmp = 1'b0;
    case (alu_fn)
      2'b00: alu_x = alu_a + alu_b;
      2'b01: alu_x = alu_a - alu_b;
      2'b10: alu_cmp = ($signed(alu_b) > $signed(alu_a));
      default: alu_x = {alu_a[W-1], alu_a[W-1:1]};
    endcase
  end

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got hang, want finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Offer one sample for a single edge and measure edges until out_valid,
  // counting the accepting edge as edge 1.
  task automatic send(input int cur, input int exp_v, input bit exp_spk, input int exp_lat,
                      input string tag);
    int lat;
    exp_q.push_back('{v: exp_v, spk: exp_spk});
    check({tag, " in_ready"}, int'(in_ready), 1);
    in_i     = cur[W-1:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < LAT_MAX) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
  endtask

  // Compare the held result against the scoreboard head and accept it.
  task automatic collect(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue, want an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " out_valid"}, int'(out_valid), 1);
      check({tag, " v_out"}, int'($signed(v_out)), e.v);
      check({tag, " spike"}, int'(spike), int'(e.spk));
    end
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    int seen;

    vecs[0]  = '{do_rst: 1'b0, cur:    40, exp_v:    40, exp_spk: 1'b0, exp_lat: 4};
    vecs[1]  = '{do_rst: 1'b0, cur:    40, exp_v:    60, exp_spk: 1'b0, exp_lat: 4};
    vecs[2]  = '{do_rst: 1'b0, cur:    70, exp_v:   100, exp_spk: 1'b0, exp_lat: 4};
    vecs[3]  = '{do_rst: 1'b0, cur:    60, exp_v:    10, exp_spk: 1'b1, exp_lat: 5};
    vecs[4]  = '{do_rst: 1'b0, cur:   500, exp_v:    10, exp_spk: 1'b0, exp_lat: 1};
    vecs[5]  = '{do_rst: 1'b0, cur:   500, exp_v:    10, exp_spk: 1'b0, exp_lat: 1};
    vecs[6]  = '{do_rst: 1'b0, cur:   100, exp_v:     5, exp_spk: 1'b1, exp_lat: 5};
    vecs[7]  = '{do_rst: 1'b1, cur: -2048, exp_v: -2048, exp_spk: 1'b0, exp_lat: 4};
    vecs[8]  = '{do_rst: 1'b0, cur: -2048, exp_v: -2048, exp_spk: 1'b0, exp_lat: 4};
    vecs[9]  = '{do_rst: 1'b1, cur:  2047, exp_v:  1947, exp_spk: 1'b1, exp_lat: 5};
    vecs[10] = '{do_rst: 1'b0, cur:     0, exp_v:  1947, exp_spk: 1'b0, exp_lat: 1};
    vecs[11] = '{do_rst: 1'b0, cur:     0, exp_v:  1947, exp_spk: 1'b0, exp_lat: 1};
    vecs[12] = '{do_rst: 1'b0, cur:  2047, exp_v:  1947, exp_spk: 1'b1, exp_lat: 5};

    // Reset values.
    tick();
    do_reset();
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset v_out", int'($signed(v_out)), 0);
    check("reset spike", int'(spike), 0);

    // Table-driven time steps.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_rst) do_reset();
      send(vecs[i].cur, vecs[i].exp_v, vecs[i].exp_spk, vecs[i].exp_lat,
           $sformatf("vec%0d", i));
      collect($sformatf("vec%0d", i));
    end

    // Backpressure: result held stable, in_valid ignored outside IDLE.
    do_reset();
    out_ready = 1'b0;
    send(40, 40, 1'b0, 4, "bp");
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_i     = 12'd999;
      check($sformatf("bp hold%0d out_valid", c), int'(out_valid), 1);
      check($sformatf("bp hold%0d v_out", c), int'($signed(v_out)), 40);
      check($sformatf("bp hold%0d spike", c), int'(spike), 0);
      check($sformatf("bp hold%0d in_ready", c), int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    collect("bp");
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("bp no stray beat", seen, 0);
    send(0, 20, 1'b0, 4, "bp next");
    collect("bp next");

    // Reset while in ADD: sample dropped, no beat, v cleared.
    in_i     = 12'd300;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst add v_out", int'($signed(v_out)), 0);
    check("rst add in_ready", int'(in_ready), 1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("rst add no beat", seen, 0);

    // Reset while a fired result is held: refractory count must clear too.
    out_ready = 1'b0;
    send(200, 100, 1'b1, 5, "rst out");
    check("rst out held spike", int'(spike), 1);
    check("rst out held v_out", int'($signed(v_out)), 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("rst out out_valid", int'(out_valid), 0);
    check("rst out spike", int'(spike), 0);
    check("rst out v_out", int'($signed(v_out)), 0);
    out_ready = 1'b1;
    send(40, 40, 1'b0, 4, "post rst");
    collect("post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
